// File: rtl/vrg_pkg.sv
// Shared constants, LMUL encoding and FSM state enum for the fp16 register gather sequencer.
package vrg_pkg;

  localparam int unsigned VLEN  = 2048;
  localparam int unsigned XLEN  = 16;
  localparam int unsigned ELEMS = VLEN / XLEN;
  localparam int unsigned AW    = 5;
  localparam int unsigned EW    = $clog2(ELEMS);
  localparam int unsigned CW    = 3;
  localparam int unsigned LW    = 4;

  localparam logic [1:0] LMUL1 = 2'd0;
  localparam logic [1:0] LMUL2 = 2'd1;
  localparam logic [1:0] LMUL4 = 2'd2;
  localparam logic [1:0] LMUL8 = 2'd3;

  typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, MRG = 2'd2, WB = 2'd3} vrg_state_e;

  // Register-group length L = 2^lmul
  function automatic logic [LW-1:0] lmul_len(input logic [1:0] lmul);
    return LW'(1) << lmul;
  endfunction

endpackage

// File: rtl/vrg_if.sv
// Issue, register-file read and writeback bus of the gather sequencer.
interface vrg_if;
  import vrg_pkg::*;

  logic            start_valid;
  logic            start_ready;
  logic [1:0]      start_lmul;
  logic [AW-1:0]   start_vs1;
  logic [AW-1:0]   start_vs2;
  logic [AW-1:0]   start_vd;
  logic            rd_en;
  logic [AW-1:0]   rd_idx_addr;
  logic [AW-1:0]   rd_tbl_addr;
  logic [VLEN-1:0] rd_idx_data;
  logic [VLEN-1:0] rd_tbl_data;
  logic            wb_valid;
  logic            wb_ready;
  logic [AW-1:0]   wb_addr;
  logic [VLEN-1:0] wb_data;

  modport master (
    input  start_valid, start_lmul, start_vs1, start_vs2, start_vd,
           rd_idx_data, rd_tbl_data, wb_ready,
    output start_ready, rd_en, rd_idx_addr, rd_tbl_addr, wb_valid, wb_addr, wb_data
  );

  modport slave (
    output start_valid, start_lmul, start_vs1, start_vs2, start_vd,
           rd_idx_data, rd_tbl_data, wb_ready,
    input  start_ready, rd_en, rd_idx_addr, rd_tbl_addr, wb_valid, wb_addr, wb_data
  );
endinterface

// File: rtl/vrg_merge.sv
// Combinational per-element gather of one returning table register into the accumulator.
module vrg_merge
  import vrg_pkg::*;
(
  input  logic [VLEN-1:0] idx_vec,
  input  logic [VLEN-1:0] tbl_vec,
  input  logic [VLEN-1:0] acc_in,
  input  logic [CW-1:0]   t_ret,
  input  logic [LW-1:0]   l_len,
  input  logic            first,
  output logic [VLEN-1:0] acc_out
);

  for (genvar e = 0; e < ELEMS; e++) begin : g_el
    logic [XLEN-1:0] ix;
    logic            hit;

    assign ix  = idx_vec[e*XLEN +: XLEN];
    // Unsigned range check over the full index, then table-register select
    assign hit = (ix < (XLEN'(l_len) << EW)) && (ix[XLEN-1:EW] == (XLEN-EW)'(t_ret));
    assign acc_out[e*XLEN +: XLEN] = hit   ? tbl_vec[32'(ix[EW-1:0]) * XLEN +: XLEN] :
                                     first ? '0 : acc_in[e*XLEN +: XLEN];
  end

endmodule

// File: rtl/vrgather_seq.sv
// fp16 register-gather sequencer over LMUL groups; one table register merged per cycle.
// Optional VRG_PERF_EN adds saturating busy-cycle and writeback-stall counters.
module vrgather_seq
  import vrg_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  vrg_if.master bus,
  output logic  busy,
  output logic  done
`ifdef VRG_PERF_EN
  ,
  output logic [31:0] perf_busy_cycles,
  output logic [31:0] perf_wb_stalls
`endif
);

  localparam logic [1:0] S_IDLE = 2'(IDLE);
  localparam logic [1:0] S_RD   = 2'(RD);
  localparam logic [1:0] S_MRG  = 2'(MRG);
  localparam logic [1:0] S_WB   = 2'(WB);

  logic [1:0]      state_q, nxt_state;
  logic [1:0]      lmul_q, nxt_lmul;
  logic [AW-1:0]   vs1_q, vs2_q, vd_q, nxt_vs1, nxt_vs2, nxt_vd;
  logic [CW-1:0]   t_q, d_q, nxt_t, nxt_d, last_idx;
  logic [LW-1:0]   l_len;
  logic            start_ready_q, rd_en_q, wb_valid_q, nxt_done;
  logic [AW-1:0]   rd_idx_q, rd_tbl_q, wb_addr_q, nxt_rd_idx, nxt_rd_tbl, nxt_wb_addr;
  logic            mrg_vld_q, first;
  logic [CW-1:0]   t_ret_q;
  logic [VLEN-1:0] idx_q, acc_q, idx_src, acc_nxt;

  assign l_len    = lmul_len(lmul_q);
  assign last_idx = CW'(l_len - LW'(1));

  // Next-state, counters and next values of the registered outputs
  always_comb begin
    nxt_state = state_q;
    nxt_lmul  = lmul_q;
    nxt_vs1   = vs1_q;
    nxt_vs2   = vs2_q;
    nxt_vd    = vd_q;
    nxt_t     = t_q;
    nxt_d     = d_q;
    nxt_done  = 1'b0;
    case (state_q)
      S_IDLE: if (bus.start_valid) begin
        nxt_lmul  = bus.start_lmul;
        nxt_vs1   = bus.start_vs1;
        nxt_vs2   = bus.start_vs2;
        nxt_vd    = bus.start_vd;
        nxt_t     = '0;
        nxt_d     = '0;
        nxt_state = S_RD;
      end
      S_RD: begin
        if (t_q == last_idx) nxt_state = S_MRG;
        else                 nxt_t     = t_q + CW'(1);
      end
      S_MRG: nxt_state = S_WB;
      S_WB: if (bus.wb_ready) begin
        if (d_q == last_idx) begin
          nxt_state = S_IDLE;
          nxt_done  = 1'b1;
        end else begin
          nxt_d     = d_q + CW'(1);
          nxt_t     = '0;
          nxt_state = S_RD;
        end
      end
      default: nxt_state = S_IDLE;
    endcase
    nxt_rd_idx  = (nxt_state == S_RD) ? nxt_vs1 + AW'(nxt_d) : rd_idx_q;
    nxt_rd_tbl  = (nxt_state == S_RD) ? nxt_vs2 + AW'(nxt_t) : rd_tbl_q;
    nxt_wb_addr = (nxt_state == S_WB) ? nxt_vd + AW'(nxt_d)  : wb_addr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      lmul_q        <= '0;
      vs1_q         <= '0;
      vs2_q         <= '0;
      vd_q          <= '0;
      t_q           <= '0;
      d_q           <= '0;
      start_ready_q <= 1'b1;
      rd_en_q       <= 1'b0;
      rd_idx_q      <= '0;
      rd_tbl_q      <= '0;
      wb_valid_q    <= 1'b0;
      wb_addr_q     <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      state_q       <= nxt_state;
      lmul_q        <= nxt_lmul;
      vs1_q         <= nxt_vs1;
      vs2_q         <= nxt_vs2;
      vd_q          <= nxt_vd;
      t_q           <= nxt_t;
      d_q           <= nxt_d;
      start_ready_q <= (nxt_state == S_IDLE);
      rd_en_q       <= (nxt_state == S_RD);
      rd_idx_q      <= nxt_rd_idx;
      rd_tbl_q      <= nxt_rd_tbl;
      wb_valid_q    <= (nxt_state == S_WB);
      wb_addr_q     <= nxt_wb_addr;
      busy          <= (nxt_state != S_IDLE);
      done          <= nxt_done;
    end
  end

  // Read data returns one cycle after the strobe; track which table register it is
  assign first   = (t_ret_q == '0);
  assign idx_src = first ? bus.rd_idx_data : idx_q;

  vrg_merge u_merge (
    .idx_vec (idx_src),
    .tbl_vec (bus.rd_tbl_data),
    .acc_in  (acc_q),
    .t_ret   (t_ret_q),
    .l_len   (l_len),
    .first   (first),
    .acc_out (acc_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mrg_vld_q <= 1'b0;
      t_ret_q   <= '0;
      idx_q     <= '0;
      acc_q     <= '0;
    end else begin
      mrg_vld_q <= rd_en_q;
      t_ret_q   <= t_q;
      if (mrg_vld_q) begin
        acc_q <= acc_nxt;
        if (first) idx_q <= bus.rd_idx_data;
      end
    end
  end

  assign bus.start_ready = start_ready_q;
  assign bus.rd_en       = rd_en_q;
  assign bus.rd_idx_addr = rd_idx_q;
  assign bus.rd_tbl_addr = rd_tbl_q;
  assign bus.wb_valid    = wb_valid_q;
  assign bus.wb_addr     = wb_addr_q;
  assign bus.wb_data     = acc_q;

`ifdef VRG_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_busy_cycles <= '0;
      perf_wb_stalls   <= '0;
    end else begin
      if (busy && (perf_busy_cycles != '1)) perf_busy_cycles <= perf_busy_cycles + 32'd1;
      if (wb_valid_q && !bus.wb_ready && (perf_wb_stalls != '1))
        perf_wb_stalls <= perf_wb_stalls + 32'd1;
    end
  end
`endif

endmodule

// File: doc/vrgather_seq.md
Name: vrgather_seq

Overview:
- Sequencing controller for the fp16 (16-bit element) register gather, extended to LMUL register groups (LMUL = 1, 2, 4, 8).
- Reads the index and table register groups from the vector register file over two synchronous read ports and merges one table register per cycle into a destination accumulator.
- Writes each destination register back through a valid/ready port.
- Sits between vector issue and the register file; one instruction in flight at a time.

Parameters:
VLEN, 2048, bits per vector register
XLEN, 16, element width in bits (fixed fp16)
ELEMS, VLEN/XLEN (128), elements per register
AW, 5, register-file address width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start_valid  in  1  instruction request
start_ready  out  1  high only in IDLE
start_lmul  in  2  0:LMUL1, 1:LMUL2, 2:LMUL4, 3:LMUL8
start_vs1  in  AW  index group base register
start_vs2  in  AW  table group base register
start_vd  in  AW  destination group base register
rd_en  out  1  read strobe for both ports
rd_idx_addr  out  AW  index read address
rd_tbl_addr  out  AW  table read address
rd_idx_data  in  VLEN  index data, valid the cycle after rd_en
rd_tbl_data  in  VLEN  table data, valid the cycle after rd_en
wb_valid  out  1  writeback valid
wb_ready  in  1  writeback accept
wb_addr  out  AW  vd + d
wb_data  out  VLEN  gathered register
busy  out  1  high when not in IDLE
done  out  1  one-cycle pulse after the final writeback handshake

Behaviour:
- Clock `clk`; reset `rst_n`, asynchronous, active-low.
- Reset values: start_ready=1; rd_en, wb_valid, busy and done = 0; addresses and wb_data = 0; FSM in IDLE; counters d and t = 0.
- Handshake: start is accepted on start_valid && start_ready. The block latches lmul, vs1, vs2 and vd, sets d=0 and t=0, and enters RD. start_valid while busy is ignored, with no effect.
- FSM states: IDLE, RD, MRG, WB.
- RD: holds for L = 2^lmul cycles, with t = 0..L-1.
  - Each cycle: rd_en=1, rd_tbl_addr = vs2+t, rd_idx_addr = vs1+d.
  - After t = L-1, go to MRG.
- Merge: each cycle after an RD issue merges the returning table register t.
  - Index source: rd_idx_data when t_ret = 0 (also captured into the index register); the captured register otherwise.
  - Per element e:
    - hit = idx[e] < L*ELEMS && idx[e]/ELEMS == t_ret.
    - acc[e] = tbl[idx[e] % ELEMS] on hit.
    - Otherwise acc[e] = 0 when t_ret = 0, else acc[e] is unchanged.
  - Result: out-of-range indices yield 0. The comparison is unsigned over the full 16 bits.
- MRG: one cycle, merges the last table register (t_ret = L-1), rd_en=0, then go to WB.
- WB: wb_valid=1, wb_addr = vd+d, wb_data = acc.
  - wb_addr and wb_data are held stable while wb_ready=0.
  - On the handshake: if d = L-1, go to IDLE and pulse done the next cycle; else d++, t=0, go to RD.
- Latency per destination register with wb_ready=1: L+2 cycles. Whole instruction: L*(L+2) cycles from start accept to the last handshake.
- Address arithmetic: base+offset, wraps modulo 32. Base alignment and group overlap of vd with vs1/vs2 are the issuer's responsibility; results are undefined if violated.
- Asynchronous reset mid-operation: immediate return to reset values; the partial instruction is discarded and no done is produced.

Optional Feature:
VRG_PERF_EN
- Defined: adds outputs perf_busy_cycles[31:0] and perf_wb_stalls[31:0].
  - perf_busy_cycles counts cycles with busy=1.
  - perf_wb_stalls counts cycles with wb_valid && !wb_ready.
  - Both saturate at all-ones and are cleared by rst_n only.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Decomposition:
- Package vrg_pkg:
  - XLEN, ELEMS, AW.
  - LMUL encoding constants and an lmul-to-L function.
  - FSM state enum {IDLE, RD, MRG, WB}.
- Sub-module vrg_merge (combinational): inputs index vector, table vector, t_ret, L, first flag and acc_in; output acc_out. It holds all ELEMS per-element selects. The controller keeps the FSM, counters, index register and accumulator.

Test Plan:
1. LMUL1, idx[e]=e, table[e]=0x3C00+e, wb_ready=1 -> one writeback to vd with wb_data == table; done 4 cycles after accept (3 cycles to handshake plus the done cycle).
2. LMUL1, idx[0]=200, idx[1]=0xFFFF, idx[2]=127 -> wb_data[0]=0, wb_data[1]=0, wb_data[2] = table[127].
3. LMUL2, vs2=8, vs1=4, vd=16, idx[0]=130, table reg 9 element 2 = 0xABCD -> wb_data[0]=0xABCD on the wb_addr=16 beat; two writebacks (16, 17); rd_tbl_addr sequence 8,9,8,9.
4. LMUL1, wb_ready=0 for 5 WB cycles -> wb_valid stays 1; wb_addr and wb_data are unchanged; done only after wb_ready=1.
5. LMUL8 in flight, start_valid pulsed during RD -> ignored, start_ready=0; exactly 8 writebacks, vd..vd+7.
6. rst_n low mid-RD for LMUL4 -> outputs return to reset values immediately; no wb_valid and no done afterward; a new start is accepted normally.
